// File: rtl/maroc_sc_serializer.sv
// MAROC slow-control serializer: captures the 829-bit configuration frame once
// after reset and shifts it out on D_SC, frame bit 0 first, then raises ss.
module maroc_sc_serializer (
    input  logic         CK_SC,
    input  logic         rst,
    input  logic         ON_OFF_otabg,
    input  logic         ON_OFF_dac,
    input  logic         small_dac,
    input  logic [9:0]   DAC2,
    input  logic [9:0]   DAC1,
    input  logic         enb_outADC,
    input  logic         inv_startCmptGray,
    input  logic         ramp_8bit,
    input  logic         ramp_10bit,
    input  logic [127:0] mask_OR_ch,
    input  logic         cmd_CK_mux,
    input  logic         d1_d2,
    input  logic         inv_discriADC,
    input  logic         polar_discri,
    input  logic         Enb_tristate,
    input  logic         valid_dc_fsb2,
    input  logic         sw_fsb2_50f,
    input  logic         sw_fsb2_100f,
    input  logic         sw_fsb2_100k,
    input  logic         sw_fsb2_50k,
    input  logic         valid_dc_fs,
    input  logic         cmd_fsb_fsu,
    input  logic         sw_fsb1_50f,
    input  logic         sw_fsb1_100f,
    input  logic         sw_fsb1_100k,
    input  logic         sw_fsb1_50k,
    input  logic         sw_fsu_100k,
    input  logic         sw_fsu_50k,
    input  logic         sw_fsu_25k,
    input  logic         sw_fsu_40f,
    input  logic         sw_fsu_20f,
    input  logic         H1H2_choice,
    input  logic         EN_ADC,
    input  logic         sw_ss_1200f,
    input  logic         sw_ss_600f,
    input  logic         sw_ss_300f,
    input  logic         ON_OFF_ss,
    input  logic         swb_buf_2p,
    input  logic         swb_buf_1p,
    input  logic         swb_buf_500f,
    input  logic         swb_buf_250f,
    input  logic         cmd_fsb,
    input  logic         cmd_ss,
    input  logic         cmd_fsu,
    input  logic [575:0] GAIN,
    input  logic [63:0]  Ctest_ch,
    output logic         D_SC,
    output logic         ss
);

    // Frame length is fixed by the ASIC, so it is not exposed as a parameter.
    localparam int unsigned FRAME_LEN = 829;
    localparam int unsigned CNT_W     = $clog2(FRAME_LEN + 1);

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [FRAME_LEN-1:0] frame_c;
    logic [FRAME_LEN-1:0] sr_q, sr_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 d_sc_d, ss_d;
    logic                 last_bit_c;

    // Fixed frame wiring, MSB (bit 828) on the left down to bit 0 on the right.
    assign frame_c = {
        Ctest_ch,
        GAIN,
        cmd_fsu, cmd_ss, cmd_fsb,
        swb_buf_250f, swb_buf_500f, swb_buf_1p, swb_buf_2p,
        ON_OFF_ss, sw_ss_300f, sw_ss_600f, sw_ss_1200f,
        EN_ADC, H1H2_choice,
        sw_fsu_20f, sw_fsu_40f, sw_fsu_25k, sw_fsu_50k, sw_fsu_100k,
        sw_fsb1_50k, sw_fsb1_100k, sw_fsb1_100f, sw_fsb1_50f,
        cmd_fsb_fsu, valid_dc_fs,
        sw_fsb2_50k, sw_fsb2_100k, sw_fsb2_100f, sw_fsb2_50f,
        valid_dc_fsb2, Enb_tristate, polar_discri, inv_discriADC, d1_d2, cmd_CK_mux,
        mask_OR_ch,
        ramp_10bit, ramp_8bit, inv_startCmptGray, enb_outADC,
        DAC1,
        DAC2,
        small_dac, ON_OFF_dac, ON_OFF_otabg
    };

    // Counter reaches FRAME_LEN once frame bit 828 is on D_SC.
    assign last_bit_c = (cnt_q == CNT_W'(FRAME_LEN));

    // State register.
    always_ff @(posedge CK_SC or posedge rst) begin
        if (rst) begin
            state_q <= LOAD;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: one load, a full shift pass, then park in DONE.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            LOAD:    state_d = SHIFT;
            SHIFT:   if (last_bit_c) state_d = DONE;
            DONE:    state_d = DONE;
            default: state_d = LOAD;
        endcase
    end

    // Output/datapath next values; D_SC always comes from a flop.
    always_comb begin
        sr_d   = sr_q;
        cnt_d  = cnt_q;
        d_sc_d = D_SC;
        ss_d   = ss;
        unique case (state_q)
            LOAD: begin
                sr_d   = frame_c;
                d_sc_d = frame_c[0];
                cnt_d  = CNT_W'(1);
                ss_d   = 1'b0;
            end
            SHIFT: begin
                if (last_bit_c) begin
                    d_sc_d = 1'b0;
                    ss_d   = 1'b1;
                end else begin
                    d_sc_d = sr_q[1];
                    sr_d   = sr_q >> 1;
                    cnt_d  = CNT_W'(cnt_q + CNT_W'(1));
                end
            end
            DONE: begin
                d_sc_d = 1'b0;
                ss_d   = 1'b1;
            end
            default: begin
                d_sc_d = 1'b0;
                ss_d   = 1'b0;
            end
        endcase
    end

    // Datapath and output registers; reset aborts any frame in flight.
    always_ff @(posedge CK_SC or posedge rst) begin
        if (rst) begin
            sr_q  <= '0;
            cnt_q <= '0;
            D_SC  <= 1'b0;
            ss    <= 1'b0;
        end else begin
            sr_q  <= sr_d;
            cnt_q <= cnt_d;
            D_SC  <= d_sc_d;
            ss    <= ss_d;
        end
    end

endmodule

// File: tb/tb_maroc_sc_serializer.sv
// Bench for maroc_sc_serializer: directed and random frames received on negedge
// and compared against a frame built from the documented bit map.
module tb_maroc_sc_serializer;

    localparam int FL = 829;

    logic         CK_SC;
    logic         rst;
    logic         ON_OFF_otabg, ON_OFF_dac, small_dac;
    logic [9:0]   DAC2, DAC1;
    logic         enb_outADC, inv_startCmptGray, ramp_8bit, ramp_10bit;
    logic [127:0] mask_OR_ch;
    logic [33:0]  flg;
    logic [575:0] GAIN;
    logic [63:0]  Ctest_ch;
    logic         D_SC, ss;

    int checks = 0;
    int errors = 0;

    maroc_sc_serializer dut (
        .CK_SC(CK_SC), .rst(rst),
        .ON_OFF_otabg(ON_OFF_otabg), .ON_OFF_dac(ON_OFF_dac), .small_dac(small_dac),
        .DAC2(DAC2), .DAC1(DAC1),
        .enb_outADC(enb_outADC), .inv_startCmptGray(inv_startCmptGray),
        .ramp_8bit(ramp_8bit), .ramp_10bit(ramp_10bit),
        .mask_OR_ch(mask_OR_ch),
        .cmd_CK_mux(flg[0]), .d1_d2(flg[1]), .inv_discriADC(flg[2]), .polar_discri(flg[3]),
        .Enb_tristate(flg[4]), .valid_dc_fsb2(flg[5]), .sw_fsb2_50f(flg[6]), .sw_fsb2_100f(flg[7]),
        .sw_fsb2_100k(flg[8]), .sw_fsb2_50k(flg[9]), .valid_dc_fs(flg[10]), .cmd_fsb_fsu(flg[11]),
        .sw_fsb1_50f(flg[12]), .sw_fsb1_100f(flg[13]), .sw_fsb1_100k(flg[14]), .sw_fsb1_50k(flg[15]),
        .sw_fsu_100k(flg[16]), .sw_fsu_50k(flg[17]), .sw_fsu_25k(flg[18]), .sw_fsu_40f(flg[19]),
        .sw_fsu_20f(flg[20]), .H1H2_choice(flg[21]), .EN_ADC(flg[22]), .sw_ss_1200f(flg[23]),
        .sw_ss_600f(flg[24]), .sw_ss_300f(flg[25]), .ON_OFF_ss(flg[26]), .swb_buf_2p(flg[27]),
        .swb_buf_1p(flg[28]), .swb_buf_500f(flg[29]), .swb_buf_250f(flg[30]), .cmd_fsb(flg[31]),
        .cmd_ss(flg[32]), .cmd_fsu(flg[33]),
        .GAIN(GAIN), .Ctest_ch(Ctest_ch),
        .D_SC(D_SC), .ss(ss)
    );

    initial CK_SC = 1'b0;
    always #5 CK_SC = ~CK_SC;

    // Hard stop if the sequence ever stalls.
    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    // Reference frame assembled field by field from the documented bit positions.
    function automatic logic [FL-1:0] ref_frame();
        logic [FL-1:0] r;
        r = '0;
        r[0] = ON_OFF_otabg;
        r[1] = ON_OFF_dac;
        r[2] = small_dac;
        for (int i = 0; i < 10; i++) r[3 + i]  = DAC2[i];
        for (int i = 0; i < 10; i++) r[13 + i] = DAC1[i];
        r[23] = enb_outADC;
        r[24] = inv_startCmptGray;
        r[25] = ramp_8bit;
        r[26] = ramp_10bit;
        for (int i = 0; i < 128; i++) r[27 + i]  = mask_OR_ch[i];
        for (int i = 0; i < 34;  i++) r[155 + i] = flg[i];
        for (int i = 0; i < 576; i++) r[189 + i] = GAIN[i];
        for (int i = 0; i < 64;  i++) r[765 + i] = Ctest_ch[i];
        return r;
    endfunction

    task automatic clear_inputs();
        ON_OFF_otabg = 0; ON_OFF_dac = 0; small_dac = 0;
        DAC2 = '0; DAC1 = '0;
        enb_outADC = 0; inv_startCmptGray = 0; ramp_8bit = 0; ramp_10bit = 0;
        mask_OR_ch = '0; flg = '0; GAIN = '0; Ctest_ch = '0;
    endtask

    task automatic randomize_inputs();
        ON_OFF_otabg = 1'($urandom); ON_OFF_dac = 1'($urandom); small_dac = 1'($urandom);
        DAC2 = 10'($urandom); DAC1 = 10'($urandom);
        enb_outADC = 1'($urandom); inv_startCmptGray = 1'($urandom);
        ramp_8bit = 1'($urandom); ramp_10bit = 1'($urandom);
        mask_OR_ch = {$urandom, $urandom, $urandom, $urandom};
        flg = 34'({$urandom, $urandom});
        for (int i = 0; i < 18; i++) GAIN[i*32 +: 32] = $urandom;
        Ctest_ch = {$urandom, $urandom};
    endtask

    // Drive a single input bit high: fid selects the field, b the bit inside it.
    task automatic set_one(input int fid, input int b);
        case (fid)
            0:  ON_OFF_otabg = 1'b1;
            1:  ON_OFF_dac = 1'b1;
            2:  small_dac = 1'b1;
            3:  DAC2[b] = 1'b1;
            4:  DAC1[b] = 1'b1;
            5:  enb_outADC = 1'b1;
            6:  inv_startCmptGray = 1'b1;
            7:  ramp_8bit = 1'b1;
            8:  ramp_10bit = 1'b1;
            9:  mask_OR_ch[b] = 1'b1;
            10: flg[b] = 1'b1;
            11: GAIN[b] = 1'b1;
            default: Ctest_ch[b] = 1'b1;
        endcase
    endtask

    task automatic chk_bit(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk_vec(input string tag, input logic [FL-1:0] obs, input logic [FL-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Release reset, receive one frame on negedges, check completion, re-assert reset.
    task automatic run_frame(input logic [FL-1:0] exp, input bit perturb, input string tag);
        logic [FL-1:0] rx;
        logic          ss_early;
        rx = '0;
        ss_early = 1'b0;
        @(negedge CK_SC);
        rst = 1'b0;
        for (int k = 0; k < FL; k++) begin
            @(negedge CK_SC);
            rx = {D_SC, rx[FL-1:1]};
            if (ss !== 1'b0) ss_early = 1'b1;
            if (perturb && k == 399) randomize_inputs();
        end
        chk_vec(tag, rx, exp);
        chk_bit({tag, "_ss_low_in_frame"}, ss_early, 1'b0);
        @(negedge CK_SC);
        chk_bit({tag, "_ss_at_830"}, ss, 1'b1);
        chk_bit({tag, "_dsc_done"}, D_SC, 1'b0);
        repeat (3) @(negedge CK_SC);
        chk_bit({tag, "_ss_hold"}, ss, 1'b1);
        rst = 1'b1;
        #1;
        chk_bit({tag, "_rst_ss"}, ss, 1'b0);
        chk_bit({tag, "_rst_dsc"}, D_SC, 1'b0);
    endtask

    int wf [17] = '{0, 1, 2, 3, 3, 4, 4, 5, 6, 7, 8, 9, 9,   11,  11,  12,  12};
    int wb [17] = '{0, 0, 0, 0, 9, 0, 9, 0, 0, 0, 0, 0, 127, 0,   575, 0,   63};
    int wi [17] = '{0, 1, 2, 3, 12,13,22,23,24,25,26,27,154, 189, 764, 765, 828};

    initial begin
        logic [FL-1:0] e;
        rst = 1'b1;
        clear_inputs();
        repeat (3) @(negedge CK_SC);
        chk_bit("reset_dsc", D_SC, 1'b0);
        chk_bit("reset_ss", ss, 1'b0);

        // Only bit 0 set.
        ON_OFF_otabg = 1'b1;
        e = '0; e[0] = 1'b1;
        run_frame(e, 1'b0, "otabg_only");

        // Both ends of Ctest_ch.
        clear_inputs();
        Ctest_ch = 64'h8000_0000_0000_0001;
        e = '0; e[765] = 1'b1; e[828] = 1'b1;
        run_frame(e, 1'b0, "ctest_ends");

        // Walking one across field boundaries.
        for (int t = 0; t < 17; t++) begin
            clear_inputs();
            set_one(wf[t], wb[t]);
            e = '0; e[wi[t]] = 1'b1;
            run_frame(e, 1'b0, $sformatf("walk_f%0d_b%0d", wf[t], wb[t]));
        end

        // Walking one across each global flag, in documented order from bit 155.
        for (int f = 0; f < 34; f++) begin
            clear_inputs();
            set_one(10, f);
            e = '0; e[155 + f] = 1'b1;
            run_frame(e, 1'b0, $sformatf("walk_flag%0d", f));
        end

        // Random frames.
        for (int n = 0; n < 3; n++) begin
            randomize_inputs();
            e = ref_frame();
            run_frame(e, 1'b0, $sformatf("random%0d", n));
        end

        // Inputs change mid-frame; the captured frame must go out unchanged.
        randomize_inputs();
        e = ref_frame();
        run_frame(e, 1'b1, "inputs_change_400");

        // Reset mid-frame, then a fresh random frame.
        randomize_inputs();
        @(negedge CK_SC);
        rst = 1'b0;
        repeat (300) @(negedge CK_SC);
        #2;
        rst = 1'b1;
        #1;
        chk_bit("abort_dsc", D_SC, 1'b0);
        chk_bit("abort_ss", ss, 1'b0);
        repeat (4) @(negedge CK_SC);
        chk_bit("abort_hold_dsc", D_SC, 1'b0);
        chk_bit("abort_hold_ss", ss, 1'b0);
        randomize_inputs();
        e = ref_frame();
        run_frame(e, 1'b0, "after_abort");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
